// File: rtl/probe_pkg.sv
// Shared types for the probe engine request path.
// Holds the sequencer state encoding and datapath widths.
package probe_pkg;

  localparam int ADDR_W = 64;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/credit_tracker.sv
// Outstanding-read counter for the request sequencer.
// Grants credit below the limit and flags stray responses.
module credit_tracker
  import probe_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic credit_ok,
  output logic empty_next,
  output logic err
);

  localparam logic [CNT_W-1:0] MAX =
    CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stray;
  logic             take;

  // a response with nothing in flight is dropped, not counted
  always_comb begin
    stray   = dec && (cnt == '0);
    take    = dec && !stray;
    cnt_nxt = cnt + CNT_W'(inc) - CNT_W'(take);
  end

  assign credit_ok  = cnt < MAX;
  assign empty_next = cnt_nxt == '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (stray) err <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_read_sequencer.sv
// Walks [start, end) by step issuing credit-limited reads.
// Completes once every issued read has returned.
module mem_read_sequencer
  import probe_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go_in,
  input  logic [ADDR_W-1:0] start_in,
  input  logic [ADDR_W-1:0] end_in,
  input  logic [ADDR_W-1:0] step_in,
  output logic              req_valid_out,
  output logic [ADDR_W-1:0] req_addr_out,
  input  logic              req_ready_in,
  input  logic              rsp_valid_in,
  output logic              busy_out,
  output logic              done_out,
  output logic [ADDR_W-1:0] req_count_out,
  output logic              err_out
);

  seq_state_t        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] lim;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W:0]   sum;
  logic              go_ok;
  logic              hs;
  logic              last;
  logic              credit_ok;
  logic              empty_next;

  assign go_ok = go_in &&
    (state == IDLE || state == DONE);

  assign req_valid_out = (state == ISSUE) && credit_ok;
  assign req_addr_out  = addr;
  assign hs = req_valid_out && req_ready_in;

  // carry out of the add ends the walk like reaching the bound
  assign sum  = {1'b0, addr} + {1'b0, step};
  assign last = sum[ADDR_W] || (sum[ADDR_W-1:0] >= lim);

  credit_tracker #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .clear      (go_ok),
    .inc        (hs),
    .dec        (rsp_valid_in),
    .credit_ok  (credit_ok),
    .empty_next (empty_next),
    .err        (err_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      addr          <= '0;
      lim           <= '0;
      step          <= '0;
      req_count_out <= '0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (go_in) begin
            addr          <= start_in;
            lim           <= end_in;
            step          <= (step_in == '0) ?
                             ADDR_W'(1) : step_in;
            req_count_out <= '0;
            if (start_in < end_in) begin
              state    <= ISSUE;
              busy_out <= 1'b1;
              done_out <= 1'b0;
            end else begin
              state    <= DONE;
              busy_out <= 1'b0;
              done_out <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (hs) begin
            addr          <= sum[ADDR_W-1:0];
            req_count_out <= req_count_out + ADDR_W'(1);
            if (last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (empty_next) begin
            state    <= DONE;
            busy_out <= 1'b0;
            done_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_sequencer.sv
// Bench for mem_read_sequencer: range table plus corner sequences.
// Two instances: default credits and a 2-credit variant.
module tb_mem_read_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go_in = 1'b0;
  logic [63:0] start_in = '0;
  logic [63:0] end_in = '0;
  logic [63:0] step_in = '0;
  logic        req_ready_in = 1'b0;
  logic        rsp_valid_in;

  logic        v1, v2, busy1, busy2, done1, done2, err1, err2;
  logic [63:0] a1, a2, cnt1, cnt2;

  logic        sel = 1'b0;
  logic        sv, sbusy, sdone, serr, hs_sel;
  logic [63:0] sa, scnt;

  logic        auto_rsp = 1'b0;
  logic        rsp_man = 1'b0;
  logic        mon_on = 1'b0;
  logic [2:0]  hist;
  logic [63:0] mexp;
  logic [63:0] expq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rsp_cyc = -1;
  int dc;

  typedef struct {
    logic [63:0] s;
    logic [63:0] lim;
    logic [63:0] st;
    int          n;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  mem_read_sequencer dut (
    .clk(clk), .rst(rst), .go_in(go_in),
    .start_in(start_in), .end_in(end_in),
    .step_in(step_in), .req_valid_out(v1),
    .req_addr_out(a1), .req_ready_in(req_ready_in),
    .rsp_valid_in(rsp_valid_in), .busy_out(busy1),
    .done_out(done1), .req_count_out(cnt1),
    .err_out(err1)
  );

  mem_read_sequencer #(.MAX_OUTSTANDING(2)) dut2 (
    .clk(clk), .rst(rst), .go_in(go_in),
    .start_in(start_in), .end_in(end_in),
    .step_in(step_in), .req_valid_out(v2),
    .req_addr_out(a2), .req_ready_in(req_ready_in),
    .rsp_valid_in(rsp_valid_in), .busy_out(busy2),
    .done_out(done2), .req_count_out(cnt2),
    .err_out(err2)
  );

  assign sv     = sel ? v2 : v1;
  assign sa     = sel ? a2 : a1;
  assign sbusy  = sel ? busy2 : busy1;
  assign sdone  = sel ? done2 : done1;
  assign serr   = sel ? err2 : err1;
  assign scnt   = sel ? cnt2 : cnt1;
  assign hs_sel = sv && req_ready_in;
  assign rsp_valid_in = auto_rsp ? hist[2] : rsp_man;

  always @(posedge clk) cyc <= cyc + 1;

  // auto responder: reply three cycles after each handshake
  always @(posedge clk or negedge rst) begin
    if (!rst) hist <= '0;
    else hist <= {hist[1:0], hs_sel};
  end

  always @(negedge clk) begin
    if (rsp_valid_in) last_rsp_cyc = cyc;
    if (mon_on && hs_sel) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL req_extra: got addr %h, none expected", sa);
      end else begin
        mexp = expq.pop_front();
        if (sa !== mexp) begin
          errors++;
          $display("FAIL req_addr: got %h expected %h", sa, mexp);
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    auto_rsp = 1'b0;
    rsp_man = 1'b0;
    go_in = 1'b0;
    req_ready_in = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    expq.delete();
  endtask

  task automatic go(input logic [63:0] s,
                    input logic [63:0] e,
                    input logic [63:0] st);
    cyc_step();
    start_in = s;
    end_in = e;
    step_in = st;
    go_in = 1'b1;
    cyc_step();
    go_in = 1'b0;
  endtask

  task automatic wait_done(output int c);
    for (int i = 0; i < 300 && !sdone; i++)
      @(negedge clk);
    chk("done_timeout", 64'(sdone), 64'd1);
    c = cyc;
  endtask

  task automatic push_range(input logic [63:0] s,
                            input logic [63:0] e,
                            input logic [63:0] st);
    logic [63:0] cur, stp;
    logic [64:0] nx;
    stp = (st == 0) ? 64'd1 : st;
    cur = s;
    if (cur < e) begin
      for (int k = 0; k < 1000; k++) begin
        expq.push_back(cur);
        nx = {1'b0, cur} + {1'b0, stp};
        if (nx[64] || nx[63:0] >= e) break;
        cur = nx[63:0];
      end
    end
  endtask

  task automatic run_range(input vec_t r);
    do_reset();
    sel = 1'b0;
    push_range(r.s, r.lim, r.st);
    mon_on = 1'b1;
    auto_rsp = 1'b1;
    req_ready_in = 1'b1;
    go(r.s, r.lim, r.st);
    @(negedge clk);
    chk("go_busy", 64'(sbusy), 64'(r.n > 0));
    chk("go_done", 64'(sdone), 64'(r.n == 0));
    chk("go_valid", 64'(sv), 64'(r.n > 0));
    wait_done(dc);
    chk("req_count", scnt, 64'(r.n));
    chk("queue_left", 64'(expq.size()), 64'd0);
    chk("err_clean", 64'(serr), 64'd0);
    chk("busy_end", 64'(sbusy), 64'd0);
    if (r.n > 0)
      chk("done_latency", 64'(dc), 64'(last_rsp_cyc + 1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{64'h100, 64'h140, 64'h10, 4};
    tbl[1] = '{64'h0, 64'h3, 64'h0, 3};
    tbl[2] = '{64'h200, 64'h200, 64'h10, 0};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFF0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h20, 1};
    tbl[4] = '{64'h0, 64'h30, 64'h10, 3};
    tbl[5] = '{64'h50, 64'h10, 64'h4, 0};
    tbl[6] = '{64'h0, 64'h5, 64'h10, 1};
    tbl[7] = '{64'h1000, 64'h1100, 64'h8, 32};

    do_reset();
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(v1), 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_done", 64'(done1), 64'd0);
    chk("rst_count", cnt1, 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_range(tbl[i]);

    // backpressure on the second request, stray go ignored
    do_reset();
    sel = 1'b0;
    push_range(64'h100, 64'h140, 64'h10);
    mon_on = 1'b1;
    auto_rsp = 1'b1;
    go(64'h100, 64'h140, 64'h10);
    req_ready_in = 1'b1;
    cyc_step();
    req_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      go_in = (i == 1);
      start_in = 64'h900;
      end_in = 64'h980;
      @(negedge clk);
      chk("bp_valid", 64'(sv), 64'd1);
      chk("bp_addr", sa, 64'h110);
      cyc_step();
    end
    go_in = 1'b0;
    req_ready_in = 1'b1;
    wait_done(dc);
    chk("bp_count", scnt, 64'd4);
    chk("bp_queue", 64'(expq.size()), 64'd0);

    // credit limit on the 2-credit instance
    do_reset();
    sel = 1'b1;
    expq.push_back(64'h0);
    expq.push_back(64'h8);
    expq.push_back(64'h10);
    expq.push_back(64'h18);
    mon_on = 1'b1;
    req_ready_in = 1'b1;
    go(64'h0, 64'h40, 64'h8);
    repeat (5) cyc_step();
    @(negedge clk);
    chk("cr_stall_valid", 64'(sv), 64'd0);
    chk("cr_stall_count", scnt, 64'd2);
    cyc_step();
    rsp_man = 1'b1;
    cyc_step();
    @(negedge clk);
    chk("cr_valid3", 64'(sv), 64'd1);
    chk("cr_addr3", sa, 64'h10);
    cyc_step();
    rsp_man = 1'b0;
    @(negedge clk);
    chk("cr_valid4", 64'(sv), 64'd1);
    chk("cr_addr4", sa, 64'h18);
    chk("cr_count3", scnt, 64'd3);
    cyc_step();
    @(negedge clk);
    chk("cr_full_valid", 64'(sv), 64'd0);
    chk("cr_count4", scnt, 64'd4);
    chk("cr_err", 64'(serr), 64'd0);
    chk("cr_queue", 64'(expq.size()), 64'd0);

    // wrap-around: single request then drain
    do_reset();
    sel = 1'b0;
    expq.push_back(64'hFFFF_FFFF_FFFF_FFF0);
    mon_on = 1'b1;
    req_ready_in = 1'b1;
    go(64'hFFFF_FFFF_FFFF_FFF0,
       64'hFFFF_FFFF_FFFF_FFFF, 64'h20);
    cyc_step();
    repeat (2) cyc_step();
    @(negedge clk);
    chk("wr_drain_busy", 64'(sbusy), 64'd1);
    chk("wr_drain_valid", 64'(sv), 64'd0);
    chk("wr_drain_done", 64'(sdone), 64'd0);
    chk("wr_count", scnt, 64'd1);
    cyc_step();
    rsp_man = 1'b1;
    cyc_step();
    rsp_man = 1'b0;
    @(negedge clk);
    chk("wr_done", 64'(sdone), 64'd1);
    chk("wr_busy", 64'(sbusy), 64'd0);

    // reset with three reads in flight, then a stray response
    do_reset();
    sel = 1'b0;
    expq.push_back(64'h0);
    expq.push_back(64'h8);
    expq.push_back(64'h10);
    mon_on = 1'b1;
    req_ready_in = 1'b1;
    go(64'h0, 64'h100, 64'h8);
    cyc_step();
    cyc_step();
    cyc_step();
    req_ready_in = 1'b0;
    @(negedge clk);
    chk("rs_pre_count", scnt, 64'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("rs_valid", 64'(sv), 64'd0);
    chk("rs_addr", sa, 64'd0);
    chk("rs_count", scnt, 64'd0);
    chk("rs_busy", 64'(sbusy), 64'd0);
    chk("rs_done", 64'(sdone), 64'd0);
    chk("rs_err", 64'(serr), 64'd0);
    cyc_step();
    rst = 1'b1;
    chk("rs_queue", 64'(expq.size()), 64'd0);
    cyc_step();
    rsp_man = 1'b1;
    cyc_step();
    rsp_man = 1'b0;
    @(negedge clk);
    chk("stray_err", 64'(serr), 64'd1);
    repeat (3) cyc_step();
    @(negedge clk);
    chk("stray_sticky", 64'(serr), 64'd1);
    chk("stray_idle", 64'(sbusy), 64'd0);
    go(64'h200, 64'h200, 64'h1);
    @(negedge clk);
    chk("stray_clear", 64'(serr), 64'd0);
    chk("stray_done", 64'(sdone), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
